// File: rtl/countdown34.sv
// countdown34: loadable saturating down-counter/timer.
// Counts a loaded value down to 0 in steps of PRESCALE clocks, then reports expiry
// with a one-cycle done pulse and an expired level.
// Optional feature macro COUNTDOWN34_AUTO_RELOAD_EN: when defined, the timer restarts
// from the last accepted nonzero load value on every expiry and stays in RUN.
module countdown34 #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             expired_o
);

    // Prescaler needs at least one bit even when every clock is a step.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [PW-1:0]    presc_q,   presc_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             expired_q, expired_d;
    logic             ready_q,   ready_d;
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q,  reload_d;
`endif

    // Next-state logic: load acceptance, prescaled stepping, expiry and abort.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        ready_d   = ready_q;
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                // ready is registered high in these states, so it gates the load.
                if (load_valid_i && ready_q) begin
                    presc_d = '0;
                    if (load_value_i != '0) begin
                        count_d   = load_value_i;
                        state_d   = S_RUN;
                        busy_d    = 1'b1;
                        expired_d = 1'b0;
                        ready_d   = 1'b0;
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
                        reload_d  = load_value_i;
`endif
                    end else begin
                        // A zero load expires immediately without ever running.
                        count_d   = '0;
                        state_d   = S_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        expired_d = 1'b1;
                        ready_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    // Abort beats a coinciding final step: no done pulse.
                    state_d   = S_IDLE;
                    count_d   = '0;
                    presc_d   = '0;
                    busy_d    = 1'b0;
                    expired_d = 1'b0;
                    ready_d   = 1'b1;
                end else if (!pause_i) begin
                    if (presc_q == PS_LAST) begin
                        presc_d = '0;
                        if (count_q == WIDTH'(1)) begin
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
                            count_d   = reload_q;
                            done_d    = 1'b1;
`else
                            count_d   = '0;
                            state_d   = S_DONE;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            expired_d = 1'b1;
                            ready_d   = 1'b1;
`endif
                        end else begin
                            // count is never 0 in RUN, so this cannot wrap.
                            count_d = count_q - WIDTH'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                count_d   = '0;
                presc_d   = '0;
                busy_d    = 1'b0;
                expired_d = 1'b0;
                ready_d   = 1'b1;
            end
        endcase
    end

    // State register with synchronous reset; all outputs come straight from flops.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
            ready_q   <= 1'b1;
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            expired_q <= expired_d;
            ready_q   <= ready_d;
`ifdef COUNTDOWN34_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign load_ready_o = ready_q;
    assign count_o      = count_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign expired_o    = expired_q;

endmodule

// File: tb/tb_countdown34.sv
// Bench for countdown34: a PRESCALE=1 and a PRESCALE=4 instance share the inputs.
module tb_countdown34;

    typedef struct packed {
        logic [5:0] cnt;
        logic       busy;
        logic       done;
        logic       expired;
        logic       ready;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [5:0] val;
        logic       ps;
        logic       ab;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [5:0] load_value = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;

    logic       ready1, busy1, done1, exp1;
    logic [5:0] cnt1;
    logic       ready4, busy4, done4, exp4;
    logic [5:0] cnt4;

    int errors = 0;
    int checks = 0;
    outs_t exp_q[$];

    always #5 clk = ~clk;

    countdown34 #(.WIDTH(6), .PRESCALE(1)) dut1 (
        .clock_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_ready_o(ready1),
        .load_value_i(load_value), .pause_i(pause), .abort_i(abort), .count_o(cnt1),
        .busy_o(busy1), .done_o(done1), .expired_o(exp1)
    );

    countdown34 #(.WIDTH(6), .PRESCALE(4)) dut4 (
        .clock_i(clk), .reset_i(reset), .load_valid_i(load_valid), .load_ready_o(ready4),
        .load_value_i(load_value), .pause_i(pause), .abort_i(abort), .count_o(cnt4),
        .busy_o(busy4), .done_o(done4), .expired_o(exp4)
    );

    function automatic outs_t o(input int c, input logic b, d, e, r);
        outs_t t;
        t.cnt = 6'(c); t.busy = b; t.done = d; t.expired = e; t.ready = r;
        return t;
    endfunction

    function automatic vec_t mk(input logic rst, lv, input int val, input logic ps, ab,
                                input outs_t e);
        vec_t v;
        v.rst = rst; v.lv = lv; v.val = 6'(val); v.ps = ps; v.ab = ab; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, then compare after the edge.
    task automatic cyc(input int sel, input logic r, lv, input int v, input logic ps, ab,
                       input outs_t e, input string nm);
        outs_t act, want;
        reset = r; load_valid = lv; load_value = 6'(v); pause = ps; abort = ab;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        act = (sel == 1) ? {cnt4, busy4, done4, exp4, ready4}
                         : {cnt1, busy1, done1, exp1, ready1};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            want = exp_q.pop_front();
            if (act !== want)begin
                errors++;
                $display("FAIL %s: got cnt=%0d busy=%b done=%b expired=%b ready=%b, want cnt=%0d busy=%b done=%b expired=%b ready=%b",
                         nm, act.cnt, act.busy, act.done, act.expired, act.ready,
                         want.cnt, want.busy, want.done, want.expired, want.ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[27];
        int e;
        logic p;
        outs_t rst_o;
        rst_o = o(0, 0, 0, 0, 1);
`ifndef COUNTDOWN34_AUTO_RELOAD_EN
        tbl[0]  = mk(1, 0, 0, 0, 0, rst_o);
        tbl[1]  = mk(1, 0, 0, 0, 0, rst_o);
        tbl[2]  = mk(0, 0, 0, 0, 0, rst_o);
        tbl[3]  = mk(0, 0, 0, 0, 1, rst_o);              // abort in IDLE: no effect
        tbl[4]  = mk(0, 1, 0, 0, 0, o(0, 0, 1, 1, 1));   // load 0 -> DONE at once
        tbl[5]  = mk(0, 0, 0, 0, 0, o(0, 0, 0, 1, 1));
        tbl[6]  = mk(0, 1, 3, 0, 0, o(3, 1, 0, 0, 0));   // restart from DONE, no done
        tbl[7]  = mk(0, 1, 9, 0, 0, o(2, 1, 0, 0, 0));   // load during RUN ignored
        tbl[8]  = mk(0, 0, 0, 1, 0, o(2, 1, 0, 0, 0));   // paused
        tbl[9]  = mk(0, 0, 0, 0, 0, o(1, 1, 0, 0, 0));
        tbl[10] = mk(0, 0, 0, 0, 0, o(0, 0, 1, 1, 1));
        tbl[11] = mk(0, 0, 0, 0, 0, o(0, 0, 0, 1, 1));
        tbl[12] = mk(0, 1, 5, 0, 0, o(5, 1, 0, 0, 0));
        tbl[13] = mk(0, 0, 0, 0, 0, o(4, 1, 0, 0, 0));
        tbl[14] = mk(0, 0, 0, 0, 0, o(3, 1, 0, 0, 0));
        tbl[15] = mk(0, 0, 0, 0, 0, o(2, 1, 0, 0, 0));
        tbl[16] = mk(0, 0, 0, 0, 0, o(1, 1, 0, 0, 0));
        tbl[17] = mk(0, 0, 0, 0, 1, rst_o);              // abort beats final step
        tbl[18] = mk(0, 0, 0, 0, 0, rst_o);
        tbl[19] = mk(0, 1, 4, 0, 0, o(4, 1, 0, 0, 0));
        tbl[20] = mk(0, 0, 0, 0, 0, o(3, 1, 0, 0, 0));
        tbl[21] = mk(1, 0, 0, 0, 0, rst_o);              // reset at count=3
        tbl[22] = mk(0, 0, 0, 0, 0, rst_o);
        tbl[23] = mk(0, 1, 1, 0, 0, o(1, 1, 0, 0, 0));
        tbl[24] = mk(0, 0, 0, 0, 0, o(0, 0, 1, 1, 1));
        tbl[25] = mk(0, 1, 2, 1, 0, o(2, 1, 0, 0, 0));   // pause ignored outside RUN
        tbl[26] = mk(0, 0, 0, 1, 1, rst_o);              // abort while paused
        for (int i = 0; i < 27; i++)
            cyc(0, tbl[i].rst, tbl[i].lv, tbl[i].val, tbl[i].ps, tbl[i].ab, tbl[i].exp,
                $sformatf("vec%0d", i));

        // Full span 33 -> 0 with PRESCALE=1, then a long hold in DONE.
        cyc(0, 0, 1, 33, 0, 0, o(33, 1, 0, 0, 0), "span_load");
        for (int i = 1; i < 33; i++)
            cyc(0, 0, 0, 0, 0, 0, o(33 - i, 1, 0, 0, 0), $sformatf("span_%0d", i));
        cyc(0, 0, 0, 0, 0, 0, o(0, 0, 1, 1, 1), "span_done");
        for (int i = 0; i < 12; i++)
            cyc(0, 0, 0, 0, 0, 0, o(0, 0, 0, 1, 1), $sformatf("hold_%0d", i));

        // Load 9 while counting 20 is ignored.
        cyc(0, 0, 1, 20, 0, 0, o(20, 1, 0, 0, 0), "ld20");
        cyc(0, 0, 1, 9, 0, 0, o(19, 1, 0, 0, 0), "ld9_ignored");
        cyc(0, 0, 0, 0, 0, 0, o(18, 1, 0, 0, 0), "after_ld9");

        // PRESCALE=4: load 3 expires 12 edges later.
        cyc(1, 1, 0, 0, 0, 0, rst_o, "p4_rst0");
        cyc(1, 1, 0, 0, 0, 0, rst_o, "p4_rst1");
        cyc(1, 0, 1, 3, 0, 0, o(3, 1, 0, 0, 0), "p4_load");
        for (int j = 1; j <= 12; j++)
            cyc(1, 0, 0, 0, 0, 0, (j == 12) ? o(0, 0, 1, 1, 1) : o(3 - j / 4, 1, 0, 0, 0),
                $sformatf("p4_step%0d", j));

        // PRESCALE=4 with a 5-cycle pause mid-run: expiry moves to edge 17.
        cyc(1, 0, 1, 3, 0, 0, o(3, 1, 0, 0, 0), "p4p_load");
        e = 0;
        for (int j = 1; j <= 17; j++) begin
            p = (j >= 5 && j <= 9);
            if (!p) e++;
            cyc(1, 0, 0, 0, p, 0, (e == 12) ? o(0, 0, 1, 1, 1) : o(3 - e / 4, 1, 0, 0, 0),
                $sformatf("p4p_step%0d", j));
        end
        cyc(1, 0, 0, 0, 0, 0, o(0, 0, 0, 1, 1), "p4p_hold");
`else
        // Auto-reload: load 2 cycles 2,1,2,1,... with done at each reload.
        cyc(0, 1, 0, 0, 0, 0, rst_o, "ar_rst0");
        cyc(0, 1, 0, 0, 0, 0, rst_o, "ar_rst1");
        cyc(0, 0, 1, 2, 0, 0, o(2, 1, 0, 0, 0), "ar_load");
        for (int j = 1; j <= 8; j++)
            cyc(0, 0, 0, 0, 0, 0, (j % 2 == 0) ? o(2, 1, 1, 0, 0) : o(1, 1, 0, 0, 0),
                $sformatf("ar_step%0d", j));
        cyc(0, 0, 0, 0, 0, 1, rst_o, "ar_abort");
        cyc(0, 0, 1, 0, 0, 0, o(0, 0, 1, 1, 1), "ar_load0");
        cyc(0, 0, 0, 0, 0, 0, o(0, 0, 0, 1, 1), "ar_hold");
`endif
        reset = 1'b0; load_valid = 1'b0; pause = 1'b0; abort = 1'b0;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
